acc_datapath: RTL
=================

ACC_DATAPATH -- requirements
Module: acc_datapath

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port RegAddr  input  4  one-hot register select; bit n selects R[n].
REQ-004 SHALL have port ALUCode  input  3  operation code, encodings per REQ-010.
REQ-005 SHALL have port Reg_CE  input  1  write accumulator into selected register(s).
REQ-006 SHALL have port CY_CE  input  1  update carry flag from ALU carry.
REQ-007 SHALL have port A_CE  input  1  update accumulator from ALU result.
REQ-008 SHALL have ports din  input  8  immediate operand for LDI; acc  output  8  accumulator; cy  output  1  carry flag; z  output  1  zero flag; rdata  output  8  current operand value.

Function
REQ-009 SHALL form operand B as bitwise OR of all registers whose RegAddr bit is set: 0 when RegAddr=0000; OR of both when two bits are set; rdata = B combinationally.
REQ-010 SHALL compute result/carry combinationally: 000 PASS B, c=0; 001 ADD A+B, c=carry-out; 010 SUB A-B, c=1 iff A<B (borrow); 011 ADC A+B+cy, c=carry-out; 100 AND; 101 OR; 110 XOR; 111 LDI din; logic ops and LDI c=0.
REQ-011 SHALL compute arithmetic at 9 bits; acc keeps bits [7:0], bit 8 is carry; wrap-around is modulo 256 (0xFF+0x01 -> 0x00, c=1; 0x00-0x01 -> 0xFF, c=1).
REQ-012 SHALL load acc <= result on a clock edge with A_CE=1; otherwise hold acc.
REQ-013 SHALL load cy <= c on a clock edge with CY_CE=1, independent of A_CE; otherwise hold cy.
REQ-014 SHALL write the pre-edge acc value into every selected register on an edge with Reg_CE=1; Reg_CE=1 with RegAddr=0000 writes nothing.
REQ-015 SHALL, when Reg_CE and A_CE are both 1, write the old acc into the register and the new result into acc in the same edge (exchange semantics).
REQ-016 SHALL make all updates visible one cycle after the edge (single-cycle latency, no stall, no handshake).
REQ-017 SHALL use the pre-edge cy as carry-in for ADC even when CY_CE=1 in that cycle.

Reset
REQ-018 SHALL, on edge with rst=1, set acc=0x00, cy=0, R0..R3=0x00, z=1, overriding every enable.
REQ-019 SHALL resume normal operation on the first edge with rst=0; an operation coinciding with reset is discarded, not replayed.

Configuration
REQ-020 SHALL, with ZERO_FLAG_EN defined, register z <= (result[7:0]==0) on every edge with A_CE=1, holding otherwise.
REQ-021 SHALL, without ZERO_FLAG_EN, keep port z and tie it constant 0; no zero-flag register exists.

Structure
REQ-022 SHALL place ALUCode encodings (PASS..LDI), data width (8) and register count (4) in shared package acc_pkg, used by acc_datapath and by the program-memory decoder.
REQ-023 SHALL implement REQ-010/011 in combinational sub-module acc_alu (inputs a, b, din, cin, code; outputs result, c); registers and flags stay in acc_datapath.

Verification
REQ-024 Reset: rst=1 one edge with A_CE=1, LDI din=0x55 -> acc=0x00, cy=0, all R=0x00, z=1 (ZERO_FLAG_EN).
REQ-025 Load/store: LDI din=0x12 A_CE=1; then Reg_CE=1 RegAddr=0001 -> R0=0x12; then RegAddr=0010 Reg_CE=1 -> R1=0x12, rdata with RegAddr=0011 = 0x12.
REQ-026 Add wrap: acc=0xFF, R2=0x01, ADD RegAddr=0100 A_CE=CY_CE=1 -> acc=0x00, cy=1, z=1; then ADC with R2 -> acc=0x02, cy=0.
REQ-027 Sub borrow: acc=0x03, R3=0x05, SUB RegAddr=1000 A_CE=CY_CE=1 -> acc=0xFE, cy=1, z=0; with CY_CE=0 cy holds prior value.
REQ-028 Exchange: acc=0xA0, R0=0x0B, PASS RegAddr=0001 A_CE=Reg_CE=1 -> acc=0x0B, R0=0xA0.
REQ-029 Enables off / no select: all CE=0 for 3 edges -> state unchanged; Reg_CE=1 RegAddr=0000 -> no register changes; without ZERO_FLAG_EN z stays 0 throughout.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator datapath and the program-memory decoder.
package acc_pkg;
   localparam int DW   = 8;
   localparam int NREG = 4;

   typedef enum logic [2:0] {
      ALU_PASS = 3'b000,
      ALU_ADD  = 3'b001,
      ALU_SUB  = 3'b010,
      ALU_ADC  = 3'b011,
      ALU_AND  = 3'b100,
      ALU_OR   = 3'b101,
      ALU_XOR  = 3'b110,
      ALU_LDI  = 3'b111
   } alu_code_e;
endpackage

// File: rtl/acc_alu.sv
// Combinational ALU: 9-bit arithmetic, bit 8 is carry (borrow for SUB).
module acc_alu
   import acc_pkg::*;
(
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] din,
   input  logic          cin,
   input  logic [2:0]    code,
   output logic [DW-1:0] result,
   output logic          c
);

   logic [DW:0] wide;

   always_comb begin
      wide = '0;
      unique case (alu_code_e'(code))
         ALU_PASS: wide = {1'b0, b};
         ALU_ADD:  wide = {1'b0, a} + {1'b0, b};
         ALU_SUB:  wide = {1'b0, a} - {1'b0, b};
         ALU_ADC:  wide = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
         ALU_AND:  wide = {1'b0, a & b};
         ALU_OR:   wide = {1'b0, a | b};
         ALU_XOR:  wide = {1'b0, a ^ b};
         ALU_LDI:  wide = {1'b0, din};
      endcase
      result = wide[DW-1:0];
      c      = wide[DW];
   end

endmodule

// File: rtl/acc_datapath.sv
// Accumulator, carry, register file and optional zero flag around acc_alu.
// Optional feature: define ZERO_FLAG_EN to build the registered zero flag.
module acc_datapath
   import acc_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [NREG-1:0] RegAddr,
   input  logic [2:0]      ALUCode,
   input  logic            Reg_CE,
   input  logic            CY_CE,
   input  logic            A_CE,
   input  logic [DW-1:0]   din,
   output logic [DW-1:0]   acc,
   output logic            cy,
   output logic            z,
   output logic [DW-1:0]   rdata
);

   logic [DW-1:0] regs [NREG];
   logic [DW-1:0] opb;
   logic [DW-1:0] result;
   logic          c;

   // Multiple selected registers are wire-ORed onto the operand bus
   always_comb begin
      opb = '0;
      for (int i = 0; i < NREG; i++) begin
         if (RegAddr[i]) opb = opb | regs[i];
      end
   end

   assign rdata = opb;

   acc_alu u_alu (
      .a      (acc),
      .b      (opb),
      .din    (din),
      .cin    (cy),
      .code   (ALUCode),
      .result (result),
      .c      (c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         cy  <= 1'b0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         if (A_CE)  acc <= result;
         if (CY_CE) cy  <= c;
         for (int i = 0; i < NREG; i++) begin
            if (Reg_CE && RegAddr[i]) regs[i] <= acc;
         end
      end
   end

`ifdef ZERO_FLAG_EN
   always_ff @(posedge clk) begin
      if (rst)       z <= 1'b1;
      else if (A_CE) z <= (result == '0);
   end
`else
   assign z = 1'b0;
`endif

endmodule
